fb_port_arbiter: RTL and testbench
==================================

// Module: fb_port_arbiter
// PURPOSE
//  Owns the single port of the 8-bit frame-buffer RAM and shares it between the display
//  scan reader and the DVI capture writer. Reads win every cycle; writes go through a
//  small buffer and drain into idle cycles. A built-in clear sequencer can blank the
//  whole buffer on request.
// PARAMETERS
//  FB_SIZE     15'd19200  number of valid bytes (80 bytes x 240 lines); legal addr 0..FB_SIZE-1
//  WBUF_DEPTH  4          write buffer entries (power of 2, 2..16)
//  CLEAR_VAL   8'h00      byte written by the clear sequence
// PORTS
//  clock_in   in   1   system clock, all logic on posedge
//  reset_n    in   1   asynchronous, active-low reset
//  rd_req     in   1   display read request, sampled each cycle, never refused
//  rd_addr    in   15  read address, sampled with rd_req
//  rd_data    out  8   read data (= ram_rdata), meaningful while rd_valid=1
//  rd_valid   out  1   read data valid strobe
//  wr_valid   in   1   capture write offer
//  wr_addr    in   15  write address
//  wr_data    in   8   write byte
//  wr_ready   out  1   write accepted this cycle when wr_valid & wr_ready
//  clr_start  in   1   one-cycle pulse, start clear (honoured only in IDLE)
//  clr_busy   out  1   clear sequence in progress
//  wr_oob     out  1   sticky: a write with addr >= FB_SIZE was dropped
//  ram_addr   out  15  RAM address (registered)
//  ram_wdata  out  8   RAM write data (registered)
//  ram_we     out  1   RAM write enable (registered)
//  ram_rdata  in   8   RAM read data, synchronous RAM, valid 1 cycle after ram_addr
// BEHAVIOUR
//  Reset (async, reset_n=0): ram_addr=0, ram_wdata=0, ram_we=0, rd_valid=0, wr_oob=0,
//   clr_busy=0, buffer emptied, clear counter=0, FSM=IDLE. Reset mid-clear aborts it;
//   buffered writes are lost.
//  Grant per cycle, fixed priority: (1) rd_req, (2) buffer not empty, (3) CLEAR write.
//  Read timing: rd_req in cycle t -> ram_addr=rd_addr, ram_we=0 in t+1 -> rd_valid=1 in
//   t+2 with rd_data=ram_rdata. Latency exactly 2; back-to-back reads give one
//   result per cycle.
//  Write buffer: FIFO of {addr,data}. wr_ready = !full && FSM==IDLE. Push on
//   wr_valid & wr_ready. Pop when granted: if addr < FB_SIZE, ram_we=1 with
//   ram_addr/ram_wdata next cycle; else the entry is discarded (ram_we=0) and wr_oob set.
//   Simultaneous push and pop with the buffer full is not allowed (wr_ready=0 when full).
//   Writes complete in arrival order.
//  FSM: IDLE --clr_start--> CLEAR (clear counter=0, clr_busy=1).
//   CLEAR: wr_ready=0; buffer still drains first (priority 2). A granted clear write puts
//   ram_addr=counter, ram_wdata=CLEAR_VAL, ram_we=1, then counter+1. The write of
//   FB_SIZE-1 -> DONE. Counter never exceeds FB_SIZE-1 (no wrap).
//   DONE: one cycle, clr_busy=0 -> IDLE. clr_start outside IDLE is ignored.
//  Idle cycle (no grant): ram_we=0, ram_addr holds previous value.
//  Writer progress: with continuous rd_req the buffer fills and wr_ready stays 0. This is
//   by design; display blanking leaves the drain slots.
// TESTING
//  1 rd_req at t, rd_addr=15'd5, RAM[5]=8'hA5 -> rd_valid=1 at t+2, rd_data=8'hA5; rd_valid=0 at t+1, t+3.
//  2 rd_req held 1 while 4 writes pushed -> wr_ready=0 after 4th; drop rd_req -> 4 ram_we pulses in order, next cycles.
//  3 write addr=15'd19200, data=8'h11 -> no ram_we for it, wr_oob=1 and stays 1 until reset_n=0.
//  4 2 writes buffered then clr_start -> both writes drain first, then 19200 clears; clr_busy falls; RAM all 8'h00.
//  5 clr_start with 50% rd_req duty -> every read returns at latency 2, clear completes, no address skipped or repeated.
//  6 reset_n=0 for 1 cycle mid-clear (counter=1000) -> all outputs at reset values immediately; FSM IDLE; wr_ready=1.

Source files
------------

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_port_arbiter
//  Description : Shares the single port of the 8-bit frame-buffer RAM between
//                the display scan reader and the DVI capture writer. Reads
//                take the port every cycle they are requested. Writes wait in
//                a small FIFO and drain into idle cycles. A clear sequencer
//                can blank the whole buffer, using slots left by both.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_port_arbiter #(
  parameter logic [14:0] FB_SIZE    = 15'd19200,
  parameter int          WBUF_DEPTH = 4,
  parameter logic [7:0]  CLEAR_VAL  = 8'h00
) (
  input  logic        clock_in,
  input  logic        reset_n,
  // display read side
  input  logic        rd_req,
  input  logic [14:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  // capture write side
  input  logic        wr_valid,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  // clear control and status
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        wr_oob,
  // RAM port
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
);

  // --------------------------------------------------------------------------
  // Local constants
  // --------------------------------------------------------------------------
  localparam int          AW          = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam logic [AW:0] C_DEPTH     = (AW+1)'(WBUF_DEPTH);
  localparam logic [AW:0] C_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0] C_CNT_ZERO  = '0;
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
  localparam logic [14:0] C_LAST_ADDR = FB_SIZE - 15'd1;

  // Sequencer states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]    state_q,     state_d;
  logic [14:0]   clr_cnt_q,   clr_cnt_d;

  logic [AW-1:0] wptr_q,      wptr_d;
  logic [AW-1:0] rptr_q,      rptr_d;
  logic [AW:0]   count_q,     count_d;
  logic [14:0]   buf_addr_q [WBUF_DEPTH];
  logic [7:0]    buf_data_q [WBUF_DEPTH];

  logic [14:0]   ram_addr_q,  ram_addr_d;
  logic [7:0]    ram_wdata_q, ram_wdata_d;
  logic          ram_we_q,    ram_we_d;
  logic          wr_oob_q,    wr_oob_d;

  // Read pipeline: stage 1 marks "address presented to RAM", stage 2 marks
  // "RAM data now on ram_rdata".
  logic          rd_s1_q;
  logic          rd_valid_q;

  // --------------------------------------------------------------------------
  // Combinational status and grants
  // --------------------------------------------------------------------------
  logic          buf_empty;
  logic          buf_full;
  logic          push;
  logic          pop;
  logic          gnt_rd;
  logic          gnt_buf;
  logic          gnt_clr;
  logic [14:0]   head_addr;
  logic [7:0]    head_data;
  logic          head_in_range;

  assign buf_empty     = (count_q == C_CNT_ZERO);
  assign buf_full      = (count_q == C_DEPTH);
  assign wr_ready      = !buf_full && (state_q == S_IDLE);
  assign push          = wr_valid && wr_ready;

  // Fixed priority: display read, then buffered write, then clear write.
  assign gnt_rd        = rd_req;
  assign gnt_buf       = !rd_req && !buf_empty;
  assign gnt_clr       = !rd_req && buf_empty && (state_q == S_CLEAR);
  assign pop           = gnt_buf;

  assign head_addr     = buf_addr_q[rptr_q];
  assign head_data     = buf_data_q[rptr_q];
  assign head_in_range = (head_addr < FB_SIZE);

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = ram_rdata;
  assign wr_oob    = wr_oob_q;
  // DONE deliberately reports not-busy for its single cycle.
  assign clr_busy  = (state_q == S_CLEAR);

  // --------------------------------------------------------------------------
  // Write buffer bookkeeping: pointers and occupancy.
  // Push while full cannot happen because wr_ready is low when full.
  // --------------------------------------------------------------------------
  // Next-state for FIFO pointers and occupancy count
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + C_PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + C_PTR_ONE;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clock_in) begin
    if (push) begin
      buf_addr_q[wptr_q] <= wr_addr;
      buf_data_q[wptr_q] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // RAM port driver. Address and write data hold when nobody is granted, so
  // an idle cycle simply re-reads the last address with the write disabled.
  // --------------------------------------------------------------------------
  // Next-state for registered RAM port and the sticky out-of-range flag
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    wr_oob_d    = wr_oob_q;
    if (gnt_rd) begin
      ram_addr_d = rd_addr;
    end else if (gnt_buf) begin
      if (head_in_range) begin
        ram_addr_d  = head_addr;
        ram_wdata_d = head_data;
        ram_we_d    = 1'b1;
      end else begin
        // Entry is dropped; the slot is consumed but the RAM is untouched.
        wr_oob_d = 1'b1;
      end
    end else if (gnt_clr) begin
      ram_addr_d  = clr_cnt_q;
      ram_wdata_d = CLEAR_VAL;
      ram_we_d    = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Clear sequencer. The counter only advances on a granted clear write and
  // stops at the last valid address, so every byte is written exactly once.
  // --------------------------------------------------------------------------
  // Next-state for the clear sequencer and its address counter
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d   = S_CLEAR;
          clr_cnt_d = 15'd0;
        end
      end
      S_CLEAR: begin
        if (gnt_clr) begin
          if (clr_cnt_q == C_LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            clr_cnt_d = clr_cnt_q + 15'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers with asynchronous active-low reset. A reset mid-clear abandons
  // the sequence and any buffered writes.
  // --------------------------------------------------------------------------
  // Control, pointer and RAM-port registers
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      clr_cnt_q   <= 15'd0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ram_addr_q  <= 15'd0;
      ram_wdata_q <= 8'h00;
      ram_we_q    <= 1'b0;
      wr_oob_q    <= 1'b0;
      rd_s1_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      wr_oob_q    <= wr_oob_d;
      rd_s1_q     <= gnt_rd;
      rd_valid_q  <= rd_s1_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_port_arbiter
//  Description : Self-checking bench for fb_port_arbiter with a synchronous
//                RAM model. Directed vector table plus multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_port_arbiter;

  localparam int FBS = 19200;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        wr_valid;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        clr_start;
  logic        clr_busy;
  logic        wr_oob;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  always #5 clk = ~clk;

  fb_port_arbiter dut (
    .clock_in  (clk),
    .reset_n   (reset_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .wr_oob    (wr_oob),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  // Synchronous RAM model, read-before-write, with a bulk pattern preload
  logic [7:0] mem [FBS];
  logic       init_req = 1'b0;

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'hA0;
  endfunction

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < FBS; i++) mem[i] <= pat(i);
    end else if (ram_we && (ram_addr < 15'(FBS))) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= (ram_addr < 15'(FBS)) ? mem[ram_addr] : 8'h00;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Vector table: inputs for one cycle, outputs expected just after its edge
  typedef struct {
    logic        rd;
    logic [14:0] ra;
    logic        wv;
    logic [14:0] wa;
    logic [7:0]  wd;
    logic        e_we;
    logic [14:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_rv;
    logic [7:0]  e_rd;
    logic        e_oob;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  // Writes expected to drain ahead of the clear sequence
  logic [14:0] pre_addr [2];
  logic [7:0]  pre_data [2];
  int          n_pre;

  task automatic run_clear(input bit reads);
    int          widx;
    int          clr_next;
    bit          done;
    bit          h1, h2, cur_rd;
    logic [14:0] a1, a2, cur_a;
    widx = 0; clr_next = 0; done = 0;
    h1 = 0; h2 = 0; a1 = '0; a2 = '0;
    wr_valid = 1'b0;
    for (int cyc = 0; cyc < 30000 && !done; cyc++) begin
      cur_rd    = reads && (cyc < 400) && ((cyc % 2) == 0);
      cur_a     = 15'(19100 + (cyc % 50));
      rd_req    = cur_rd;
      rd_addr   = cur_a;
      // second pulse lands mid-clear and must be ignored
      clr_start = (cyc == 0) || (reads && cyc == 601);
      tick;
      h2 = h1; a2 = a1; h1 = cur_rd; a1 = cur_a;
      if (reads) begin
        chk("rd_latency", 32'(rd_valid), 32'(h2));
        if (h2) chk("rd_data", 32'(rd_data), 32'(pat(int'(a2))));
        if (h1) begin
          chk("rd_grant_we", 32'(ram_we), 32'd0);
          chk("rd_grant_addr", 32'(ram_addr), 32'(a1));
        end
      end
      if (ram_we) begin
        if (widx < n_pre) begin
          chk("drain_addr", 32'(ram_addr), 32'(pre_addr[widx]));
          chk("drain_data", 32'(ram_wdata), 32'(pre_data[widx]));
          widx++;
        end else begin
          chk("clr_addr", 32'(ram_addr), 32'(clr_next));
          chk("clr_data", 32'(ram_wdata), 32'h00);
          clr_next++;
        end
      end
      if (cyc == 0) begin
        chk("clr_busy_rise", 32'(clr_busy), 32'd1);
        chk("clr_wr_ready", 32'(wr_ready), 32'd0);
      end
      if (!clr_busy) done = 1;
    end
    clr_start = 1'b0;
    rd_req    = 1'b0;
    chk("clr_done", 32'(done), 32'd1);
    chk("clr_count", 32'(clr_next), 32'(FBS));
    chk("pre_drained", 32'(widx), 32'(n_pre));
    chk("done_wr_ready", 32'(wr_ready), 32'd0);
    tick;
    chk("idle_wr_ready", 32'(wr_ready), 32'd1);
    chk("idle_clr_busy", 32'(clr_busy), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int nz;
    bit found;

    //               rd  ra          wv  wa          wd     we  addr        wd     rv  rd     oob
    tbl[0]  = '{1'b1, 15'd5,     1'b0, 15'd0,     8'h00, 1'b0, 15'd5,     8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 15'd0,     1'b0, 15'd0,     8'h00, 1'b0, 15'd5,     8'h00, 1'b1, 8'hA5, 1'b0};
    tbl[2]  = '{1'b0, 15'd0,     1'b0, 15'd0,     8'h00, 1'b0, 15'd5,     8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 15'd0,     1'b1, 15'd100,   8'h3C, 1'b0, 15'd5,     8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 15'd0,     1'b0, 15'd0,     8'h00, 1'b1, 15'd100,   8'h3C, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 15'd100,   1'b1, 15'd7,     8'h99, 1'b0, 15'd100,   8'h00, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 15'd0,     1'b0, 15'd0,     8'h00, 1'b1, 15'd7,     8'h99, 1'b1, 8'h3C, 1'b0};
    tbl[7]  = '{1'b1, 15'd7,     1'b0, 15'd0,     8'h00, 1'b0, 15'd7,     8'h00, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 15'd5,     1'b0, 15'd0,     8'h00, 1'b0, 15'd5,     8'h00, 1'b1, 8'h99, 1'b0};
    tbl[9]  = '{1'b0, 15'd0,     1'b0, 15'd0,     8'h00, 1'b0, 15'd5,     8'h00, 1'b1, 8'hA5, 1'b0};
    tbl[10] = '{1'b0, 15'd0,     1'b1, 15'd19200, 8'h11, 1'b0, 15'd5,     8'h00, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 15'd0,     1'b0, 15'd0,     8'h00, 1'b0, 15'd5,     8'h00, 1'b0, 8'h00, 1'b1};
    tbl[12] = '{1'b0, 15'd0,     1'b1, 15'd19199, 8'hE1, 1'b0, 15'd5,     8'h00, 1'b0, 8'h00, 1'b1};
    tbl[13] = '{1'b0, 15'd0,     1'b0, 15'd0,     8'h00, 1'b1, 15'd19199, 8'hE1, 1'b0, 8'h00, 1'b1};
    tbl[14] = '{1'b1, 15'd19199, 1'b0, 15'd0,     8'h00, 1'b0, 15'd19199, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[15] = '{1'b0, 15'd0,     1'b0, 15'd0,     8'h00, 1'b0, 15'd19199, 8'h00, 1'b1, 8'hE1, 1'b1};
    tbl[16] = '{1'b0, 15'd0,     1'b0, 15'd0,     8'h00, 1'b0, 15'd19199, 8'h00, 1'b0, 8'h00, 1'b1};

    // Reset with RAM preload
    reset_n = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; clr_start = 1'b0;
    init_req = 1'b1;
    tick;
    init_req = 1'b0;
    chk("rst_ram_addr",  32'(ram_addr),  32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_ram_we",    32'(ram_we),    32'd0);
    chk("rst_rd_valid",  32'(rd_valid),  32'd0);
    chk("rst_wr_oob",    32'(wr_oob),    32'd0);
    chk("rst_clr_busy",  32'(clr_busy),  32'd0);
    chk("rst_wr_ready",  32'(wr_ready),  32'd1);
    reset_n = 1'b1;
    tick;

    // Table-driven single-cycle vectors
    for (int i = 0; i < NV; i++) begin
      rd_req = tbl[i].rd; rd_addr = tbl[i].ra;
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      tick;
      chk($sformatf("v%0d_we", i),   32'(ram_we),   32'(tbl[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
      if (tbl[i].e_we) chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(tbl[i].e_wd));
      chk($sformatf("v%0d_rv", i),   32'(rd_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("v%0d_rdata", i), 32'(rd_data), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d_oob", i),  32'(wr_oob),   32'(tbl[i].e_oob));
      chk($sformatf("v%0d_wrdy", i), 32'(wr_ready), 32'd1);
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    tick;

    // Continuous reads starve the buffer until it is full
    rd_req = 1'b1; rd_addr = 15'd0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 15'(200 + i); wr_data = 8'(8'h50 + i);
      chk("push_ready", 32'(wr_ready), 32'd1);
      tick;
      chk("push_no_we", 32'(ram_we), 32'd0);
    end
    chk("full_ready", 32'(wr_ready), 32'd0);
    wr_addr = 15'd204; wr_data = 8'h54;
    tick;
    chk("full_hold_ready", 32'(wr_ready), 32'd0);
    chk("full_hold_we", 32'(ram_we), 32'd0);
    rd_req = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("drain4_we",   32'(ram_we),    32'd1);
      chk("drain4_addr", 32'(ram_addr),  32'(200 + i));
      chk("drain4_data", 32'(ram_wdata), 32'(8'h50 + i));
    end
    tick;
    chk("drain4_end_we", 32'(ram_we), 32'd0);
    chk("drain4_ready", 32'(wr_ready), 32'd1);

    // Two buffered writes, then a clear: writes drain first
    rd_req = 1'b1; rd_addr = 15'd1;
    pre_addr[0] = 15'd300; pre_data[0] = 8'h77;
    pre_addr[1] = 15'd301; pre_data[1] = 8'h78;
    n_pre = 2;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_addr = pre_addr[i]; wr_data = pre_data[i];
      tick;
    end
    wr_valid = 1'b0;
    run_clear(1'b0);
    nz = 0;
    for (int i = 0; i < FBS; i++) if (mem[i] !== 8'h00) nz++;
    chk("ram_blank", 32'(nz), 32'd0);

    // Clear interleaved with 50% read duty
    init_req = 1'b1;
    tick;
    init_req = 1'b0;
    tick;
    tick;
    n_pre = 0;
    run_clear(1'b1);

    // Asynchronous reset in the middle of a clear
    chk("oob_sticky", 32'(wr_oob), 32'd1);
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
      tick;
      if (ram_we && ram_addr == 15'd999) found = 1;
    end
    chk("mid_clear_reached", 32'(found), 32'd1);
    chk("mid_clear_busy", 32'(clr_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_ram_addr",  32'(ram_addr),  32'd0);
    chk("arst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("arst_ram_we",    32'(ram_we),    32'd0);
    chk("arst_rd_valid",  32'(rd_valid),  32'd0);
    chk("arst_wr_oob",    32'(wr_oob),    32'd0);
    chk("arst_clr_busy",  32'(clr_busy),  32'd0);
    chk("arst_wr_ready",  32'(wr_ready),  32'd1);
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_we",   32'(ram_we),   32'd0);
      chk("post_rst_busy", 32'(clr_busy), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
